// File: rtl/result_presenter_pkg.sv
// +----------------------------------------------------------------------+
// | result_presenter_pkg                                                 |
// | Shared state encoding, debounce default and seven-segment patterns.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package result_presenter_pkg;

  localparam int DEB_CYCLES_DEFAULT = 1000;
  localparam int WORD_W             = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHOW_G = 2'd1;
  localparam logic [1:0] ST_SHOW_H = 2'd2;
  localparam logic [1:0] ST_ACK    = 2'd3;

  // Active-low gfedcba patterns, entry [n] is hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

`default_nettype wire

// File: rtl/result_presenter_hex7seg.sv
// +----------------------------------------------------------------------+
// | hex7seg                                                              |
// | One hex nibble to an active-low gfedcba seven-segment pattern.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module hex7seg
  import result_presenter_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

`default_nettype wire

// File: rtl/result_presenter.sv
// +----------------------------------------------------------------------+
// | result_presenter                                                     |
// | Latches g/h on done, steps g -> h -> ack on debounced key presses.   |
// | Optional macro PRESENTER_PARITY_EN adds a registered parity output.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module result_presenter
  import result_presenter_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              key_n,
  input  logic              done,
  input  logic [WORD_W-1:0] g,
  input  logic [WORD_W-1:0] h,
  output logic              ack,
  output logic              valid,
  output logic              sel_h,
  output logic [WORD_W-1:0] show,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
`ifdef PRESENTER_PARITY_EN
  output logic              parity,
`endif
  output logic [6:0]        hex3
);

  localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic              key_sync1_q, key_sync2_q;
  logic              key_db_q, key_db_d;
  logic [CNT_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              press_q, press_d;
  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] g_lat_q, g_lat_d, h_lat_q, h_lat_d;
  logic [WORD_W-1:0] show_q, show_d;
  logic              ack_q, ack_d, valid_q, valid_d, sel_h_q, sel_h_d;
`ifdef PRESENTER_PARITY_EN
  logic              parity_q, parity_d;
`endif

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      key_sync1_q <= 1'b1;
      key_sync2_q <= 1'b1;
      key_db_q    <= 1'b1;
      deb_cnt_q   <= '0;
      press_q     <= 1'b0;
      state_q     <= ST_IDLE;
      g_lat_q     <= '0;
      h_lat_q     <= '0;
      show_q      <= '0;
      ack_q       <= 1'b0;
      valid_q     <= 1'b0;
      sel_h_q     <= 1'b0;
`ifdef PRESENTER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      key_sync1_q <= key_n;
      key_sync2_q <= key_sync1_q;
      key_db_q    <= key_db_d;
      deb_cnt_q   <= deb_cnt_d;
      press_q     <= press_d;
      state_q     <= state_d;
      g_lat_q     <= g_lat_d;
      h_lat_q     <= h_lat_d;
      show_q      <= show_d;
      ack_q       <= ack_d;
      valid_q     <= valid_d;
      sel_h_q     <= sel_h_d;
`ifdef PRESENTER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Debounced level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    key_db_d  = key_db_q;
    deb_cnt_d = '0;
    if (key_sync2_q != key_db_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        key_db_d = key_sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    press_d = key_db_q & ~key_db_d;
  end

  always_comb begin
    state_d = state_q;
    g_lat_d = g_lat_q;
    h_lat_d = h_lat_q;
    case (state_q)
      ST_IDLE: begin
        if (done) begin
          g_lat_d = g;
          h_lat_d = h;
          state_d = ST_SHOW_G;
        end
      end
      ST_SHOW_G: if (press_q) state_d = ST_SHOW_H;
      ST_SHOW_H: if (press_q) state_d = ST_ACK;
      ST_ACK:    if (!done)   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    show_d  = '0;
    ack_d   = 1'b0;
    valid_d = 1'b0;
    sel_h_d = 1'b0;
    case (state_d)
      ST_SHOW_G: begin
        valid_d = 1'b1;
        show_d  = g_lat_d;
      end
      ST_SHOW_H: begin
        valid_d = 1'b1;
        sel_h_d = 1'b1;
        show_d  = h_lat_d;
      end
      ST_ACK:  ack_d = 1'b1;
      default: ;
    endcase
`ifdef PRESENTER_PARITY_EN
    parity_d = ~^show_d;
`endif
  end

  logic [3:0][6:0] hex_w;

  for (genvar i = 0; i < 4; i++) begin : g_hex
    hex7seg u_hex7seg (
      .nibble (show_q[4*i +: 4]),
      .seg    (hex_w[i])
    );
  end

  assign ack   = ack_q;
  assign valid = valid_q;
  assign sel_h = sel_h_q;
  assign show  = show_q;
  assign hex0  = hex_w[0];
  assign hex1  = hex_w[1];
  assign hex2  = hex_w[2];
  assign hex3  = hex_w[3];
`ifdef PRESENTER_PARITY_EN
  assign parity = parity_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_result_presenter.sv
// +----------------------------------------------------------------------+
// | tb_result_presenter                                                  |
// | Self-checking bench for result_presenter with DEB_CYCLES = 8.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_result_presenter;

  typedef struct packed {
    logic        ack;
    logic        valid;
    logic        sel_h;
    logic [15:0] show;
  } exp_t;

  logic        CLOCK_50 = 1'b0;
  logic        rst;
  logic        key_n;
  logic        done;
  logic [15:0] g, h;
  logic        ack, valid, sel_h;
  logic [15:0] show;
  logic [6:0]  hex0, hex1, hex2, hex3;
`ifdef PRESENTER_PARITY_EN
  logic        parity;
`endif

  exp_t sb_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  result_presenter #(.DEB_CYCLES(8)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .key_n    (key_n),
    .done     (done),
    .g        (g),
    .h        (h),
    .ack      (ack),
    .valid    (valid),
    .sel_h    (sel_h),
    .show     (show),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
`ifdef PRESENTER_PARITY_EN
    .parity   (parity),
`endif
    .hex3     (hex3)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; key_n = 1'b1; done = 1'b0; g = 16'h0; h = 16'h0;
    sb_q.push_back('{ack: 1'b0, valid: 1'b0, sel_h: 1'b0, show: 16'h0000});
    tick(3);
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL in_reset: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
`ifdef PRESENTER_PARITY_EN
    n_checks++;
    if (parity !== 1'b0) $display("FAIL parity_reset: got %b, expected 0", parity);
    else n_pass++;
`endif
    rst = 1'b1;
    sb_q.push_back('{ack: 1'b0, valid: 1'b0, sel_h: 1'b0, show: 16'h0000});
    tick(2);
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL idle_after_reset: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
    n_checks++;
    if (hex0 !== seg_of(4'h0)) $display("FAIL hex0_idle: got %b, expected %b", hex0, seg_of(4'h0));
    else n_pass++;
  endtask

  task automatic test_capture;
    done = 1'b1; g = 16'h1234; h = 16'hABCD;
    sb_q.push_back('{ack: 1'b0, valid: 1'b1, sel_h: 1'b0, show: 16'h1234});
    tick(1);
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL capture_g: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
    n_checks++;
    if ({hex3, hex2, hex1, hex0} !== {seg_of(4'h1), seg_of(4'h2), seg_of(4'h3), seg_of(4'h4)})
      $display("FAIL hex_1234: got %b %b %b %b, expected %b %b %b %b", hex3, hex2, hex1, hex0,
               seg_of(4'h1), seg_of(4'h2), seg_of(4'h3), seg_of(4'h4));
    else n_pass++;
    g = 16'hFFFF; done = 1'b0;
    sb_q.push_back('{ack: 1'b0, valid: 1'b1, sel_h: 1'b0, show: 16'h1234});
    tick(4);
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL latch_hold: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
  endtask

  task automatic test_debounce;
    int k;
    key_n = 1'b0;
    tick(5);
    key_n = 1'b1;
    sb_q.push_back('{ack: 1'b0, valid: 1'b1, sel_h: 1'b0, show: 16'h1234});
    tick(15);
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL short_press: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
    key_n = 1'b0;
    sb_q.push_back('{ack: 1'b0, valid: 1'b1, sel_h: 1'b0, show: 16'h1234});
    tick(9);
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL press_too_early: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
    sb_q.push_back('{ack: 1'b0, valid: 1'b1, sel_h: 1'b1, show: 16'hABCD});
    k = 0;
    while (sel_h !== 1'b1 && k < 20) begin
      tick(1);
      k++;
    end
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL press_to_h: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
    sb_q.push_back('{ack: 1'b0, valid: 1'b1, sel_h: 1'b1, show: 16'hABCD});
    tick(20);
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL held_stays_h: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
  endtask

  task automatic test_ack;
    int k;
    key_n = 1'b1;
    tick(15);
    done = 1'b1;
    key_n = 1'b0;
    sb_q.push_back('{ack: 1'b1, valid: 1'b0, sel_h: 1'b0, show: 16'h0000});
    k = 0;
    while (ack !== 1'b1 && k < 25) begin
      tick(1);
      k++;
    end
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL enter_ack: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
    sb_q.push_back('{ack: 1'b1, valid: 1'b0, sel_h: 1'b0, show: 16'h0000});
    tick(5);
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL ack_held: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
    done = 1'b0;
    sb_q.push_back('{ack: 1'b0, valid: 1'b0, sel_h: 1'b0, show: 16'h0000});
    tick(1);
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL ack_release: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
  endtask

  // Key stays held from the ack step into the next capture.
  task automatic test_held_key;
    int k;
    tick(5);
    done = 1'b1; g = 16'h00AA; h = 16'h00BB;
    sb_q.push_back('{ack: 1'b0, valid: 1'b1, sel_h: 1'b0, show: 16'h00AA});
    tick(1);
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL capture_aa: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
    done = 1'b0;
    sb_q.push_back('{ack: 1'b0, valid: 1'b1, sel_h: 1'b0, show: 16'h00AA});
    tick(20);
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL held_key_ignored: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
    key_n = 1'b1;
    tick(15);
    key_n = 1'b0;
    sb_q.push_back('{ack: 1'b0, valid: 1'b1, sel_h: 1'b1, show: 16'h00BB});
    k = 0;
    while (sel_h !== 1'b1 && k < 25) begin
      tick(1);
      k++;
    end
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL new_press_to_h: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int k;
    @(posedge CLOCK_50);
    #5;
    rst = 1'b0;
    key_n = 1'b1;
    sb_q.push_back('{ack: 1'b0, valid: 1'b0, sel_h: 1'b0, show: 16'h0000});
    #1;
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL async_reset: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
    tick(2);
    done = 1'b1; g = 16'h0001; h = 16'h0003;
    rst = 1'b1;
    sb_q.push_back('{ack: 1'b0, valid: 1'b1, sel_h: 1'b0, show: 16'h0001});
    tick(1);
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL capture_after_reset: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
`ifdef PRESENTER_PARITY_EN
    n_checks++;
    if (parity !== 1'b0) $display("FAIL parity_0001: got %b, expected 0", parity);
    else n_pass++;
`endif
    done = 1'b0;
    tick(3);
    key_n = 1'b0;
    sb_q.push_back('{ack: 1'b0, valid: 1'b1, sel_h: 1'b1, show: 16'h0003});
    k = 0;
    while (sel_h !== 1'b1 && k < 25) begin
      tick(1);
      k++;
    end
    e = sb_q.pop_front();
    n_checks++;
    if ({ack, valid, sel_h, show} !== e)
      $display("FAIL show_h_0003: got ack=%b valid=%b sel_h=%b show=%h, expected %b %b %b %h",
               ack, valid, sel_h, show, e.ack, e.valid, e.sel_h, e.show);
    else n_pass++;
`ifdef PRESENTER_PARITY_EN
    n_checks++;
    if (parity !== 1'b1) $display("FAIL parity_0003: got %b, expected 1", parity);
    else n_pass++;
`endif
    key_n = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_capture();
    test_debounce();
    test_ack();
    test_held_key();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
